// File: rtl/ef_uart_pkg.sv
// Shared definitions for the EF_UART packet deframer: SOF marker, FSM encoding, checksum step.
package ef_uart_pkg;

    localparam logic [7:0] SOF = 8'h7E;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        OUT  = 3'd4
    } state_e;

    // Running mod-256 sum; a frame is good when LEN + payload + CHK folds to zero.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/ef_uart_pkt_buf.sv
// Payload buffer for the deframer: register array, synchronous write, combinational read.
module ef_uart_pkt_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ef_uart_pkt_deframer.sv
// Pops bytes from the EF_UART RX FIFO, hunts for SOF/LEN/payload/CHK frames, checks the
// checksum and replays good payloads on a valid/ready stream; bad frames raise error pulses.
module ef_uart_pkt_deframer
    import ef_uart_pkg::*;
#(
    parameter  int MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] timeout,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_rd,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        pkt_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        to_err,
    output logic        busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wptr_q, wptr_d;
    logic [LEN_W-1:0]  rptr_q, rptr_d;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       to_cnt_q, to_cnt_d;

    logic              pop;
    logic              in_frame;
    logic              tmo_hit;
    logic              buf_we;
    logic [7:0]        buf_rdata;

    ef_uart_pkt_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wptr_q[IDX_W-1:0]),
        .wdata_i (fifo_rdata),
        .raddr_i (rptr_q[IDX_W-1:0]),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            len_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            sum_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            sum_q    <= sum_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // The FIFO is never popped while a payload is being replayed, so it back-pressures the UART.
    assign pop      = rst_n & en & ~fifo_empty & (state_q != OUT);
    assign in_frame = (state_q == LEN) | (state_q == DATA) | (state_q == CHK);
    assign tmo_hit  = en & in_frame & fifo_empty & (timeout != 16'd0) &
                      (to_cnt_q == timeout - 16'd1);
    assign busy     = (state_q != HUNT);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        sum_d    = sum_q;
        to_cnt_d = to_cnt_q;
        buf_we   = 1'b0;
        fifo_rd  = 1'b0;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_last   = 1'b0;
        pkt_ok   = 1'b0;
        crc_err  = 1'b0;
        len_err  = 1'b0;
        to_err   = 1'b0;

        if (!en) begin
            state_d  = HUNT;
            len_d    = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            sum_d    = '0;
            to_cnt_d = '0;
        end else begin
            fifo_rd = pop;

            if (pop) begin
                to_cnt_d = '0;
            end else if (in_frame && fifo_empty && to_cnt_q != 16'hFFFF) begin
                to_cnt_d = to_cnt_q + 16'd1;
            end

            case (state_q)
                HUNT: begin
                    if (pop && fifo_rdata == SOF) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (pop) begin
                        if (fifo_rdata == 8'h00 || fifo_rdata > 8'(MAX_LEN)) begin
                            len_err = 1'b1;
                            state_d = HUNT;
                        end else begin
                            len_d   = LEN_W'(fifo_rdata);
                            sum_d   = fifo_rdata;
                            wptr_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (pop) begin
                        buf_we = 1'b1;
                        sum_d  = chk_add(sum_q, fifo_rdata);
                        wptr_d = wptr_q + LEN_W'(1);
                        if (wptr_q == len_q - LEN_W'(1)) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (pop) begin
                        if (chk_add(sum_q, fifo_rdata) == 8'h00) begin
                            rptr_d  = '0;
                            state_d = OUT;
                        end else begin
                            crc_err = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end
                OUT: begin
                    m_valid = 1'b1;
                    m_data  = buf_rdata;
                    m_last  = (rptr_q == len_q - LEN_W'(1));
                    if (m_ready) begin
                        if (m_last) begin
                            pkt_ok  = 1'b1;
                            rptr_d  = '0;
                            state_d = HUNT;
                        end else begin
                            rptr_d = rptr_q + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            // A stalled frame is abandoned; the counter restarts on the next pop.
            if (tmo_hit) begin
                to_err   = 1'b1;
                to_cnt_d = '0;
                state_d  = HUNT;
            end
        end
    end

endmodule
